// File: rtl/jtframe_8751_pkg.sv
// Shared constants for the 8751 MCU mailbox: default MCU-side register
// addresses, status bit positions and the status byte builder.
package jtframe_8751_pkg;

  localparam logic [15:0] CMD_ADDR_DEF = 16'h0000;
  localparam logic [15:0] ACK_ADDR_DEF = 16'h0001;
  localparam logic [15:0] RPL_ADDR_DEF = 16'h0002;
  localparam logic [15:0] STS_ADDR_DEF = 16'h0003;

  localparam int ST_CMD_FULL = 0;
  localparam int ST_RPL_FULL = 1;
  localparam int ST_OVR      = 2;

  // Same byte is presented to both the main CPU and the MCU.
  function automatic logic [7:0] status_byte(input logic cmd_full,
                                             input logic reply_full,
                                             input logic overrun);
    logic [7:0] s;
    s              = 8'h00;
    s[ST_CMD_FULL] = cmd_full;
    s[ST_RPL_FULL] = reply_full;
    s[ST_OVR]      = overrun;
    return s;
  endfunction

endpackage

// File: rtl/jtframe_8751_edge.sv
// Enable-qualified edge detector. FALL selects falling instead of rising edge.
// After reset the detector stays disarmed until it samples din low, so a
// strobe already high at reset release never produces an event.
module jtframe_8751_edge #(
  parameter bit FALL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic pulse
);

  logic last;
  logic armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last  <= 1'b0;
      armed <= 1'b0;
    end else if (en) begin
      last <= din;
      if (!din) armed <= 1'b1;
    end
  end

  always_comb begin
    pulse = 1'b0;
    if (en && armed) begin
      if (FALL) pulse = ~din & last;
      else      pulse = din & ~last;
    end
  end

endmodule

// File: rtl/jtframe_8751_mailbox.sv
// Command/reply mailbox between a main CPU and an 8751 MCU external bus,
// with an int0n pulse to the MCU on every command write.
module jtframe_8751_mailbox
  import jtframe_8751_pkg::*;
#(
  parameter logic [15:0] CMD_ADDR = CMD_ADDR_DEF,
  parameter logic [15:0] ACK_ADDR = ACK_ADDR_DEF,
  parameter logic [15:0] RPL_ADDR = RPL_ADDR_DEF,
  parameter logic [15:0] STS_ADDR = STS_ADDR_DEF,
  parameter int          INT_LEN  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        main_cs,
  input  logic        main_addr,
  input  logic        main_we,
  input  logic        main_rd,
  input  logic [7:0]  main_din,
  output logic [7:0]  main_dout,
  output logic        main_irq,
  input  logic [15:0] x_addr,
  input  logic [7:0]  x_dout,
  input  logic        x_wr,
  output logic [7:0]  x_din,
  output logic        int0n
);

  localparam logic [7:0] INT_LOAD = INT_LEN[7:0];

  logic [7:0] cmd_reg;
  logic [7:0] reply_reg;
  logic       cmd_full;
  logic       reply_full;
  logic       overrun;
  logic [7:0] int_cnt;
  logic [7:0] status;

  logic main_wr_ev;
  logic main_rd_ev;
  logic x_wr_ev;
  logic mcu_ack;
  logic mcu_rpl;

  jtframe_8751_edge #(.FALL(1'b0)) u_main_wr (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .din   (main_cs & main_we),
    .pulse (main_wr_ev)
  );

  jtframe_8751_edge #(.FALL(1'b1)) u_main_rd (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .din   (main_cs & main_rd),
    .pulse (main_rd_ev)
  );

  // MCU strobe is only looked at on cen cycles, so the MCU side freezes with cen low.
  jtframe_8751_edge #(.FALL(1'b0)) u_x_wr (
    .clk   (clk),
    .rst   (rst),
    .en    (cen),
    .din   (x_wr),
    .pulse (x_wr_ev)
  );

  assign mcu_ack = x_wr_ev && (x_addr == ACK_ADDR);
  assign mcu_rpl = x_wr_ev && (x_addr == RPL_ADDR);

  // Set events take priority over same-cycle clears on every flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_reg  <= 8'h00;
      cmd_full <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (main_wr_ev) begin
        cmd_reg  <= main_din;
        cmd_full <= 1'b1;
      end else if (mcu_ack) begin
        cmd_full <= 1'b0;
      end
      if (main_wr_ev && cmd_full) overrun <= 1'b1;
      else if (main_rd_ev && main_addr) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reply_reg  <= 8'h00;
      reply_full <= 1'b0;
    end else begin
      if (mcu_rpl) begin
        reply_reg  <= x_dout;
        reply_full <= 1'b1;
      end else if (main_rd_ev && !main_addr) begin
        reply_full <= 1'b0;
      end
    end
  end

  // A new command reloads the counter, stretching a pulse already in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_cnt <= 8'h00;
    end else if (main_wr_ev) begin
      int_cnt <= INT_LOAD;
    end else if (cen && (int_cnt != 8'h00)) begin
      int_cnt <= int_cnt - 8'h01;
    end
  end

  always_comb begin
    status = status_byte(cmd_full, reply_full, overrun);
  end

  always_comb begin
    main_dout = main_addr ? status : reply_reg;
  end

  always_comb begin
    x_din = 8'hFF;
    if (x_addr == CMD_ADDR)      x_din = cmd_reg;
    else if (x_addr == STS_ADDR) x_din = status;
  end

  assign main_irq = reply_full;
  assign int0n    = (int_cnt == 8'h00);

endmodule
